// File: rtl/s2p_write_ctrl.sv
// Serial-to-parallel write controller: shifts one word in LSB first, strobes
// it as a parallel word, then pulses the MRAM write enable at a counting address.
module s2p_write_ctrl #(
   parameter int BUS_WIDTH  = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int WR_PULSE   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  serial_in,
   input  logic                  load_addr,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic                  clr_err,
   output logic                  s2p_en,
   output logic                  s2p_din,
   output logic                  s2p_send,
   output logic                  mram_we,
   output logic [ADDR_WIDTH-1:0] mram_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int BIT_W = $clog2(BUS_WIDTH + 1);
   localparam int WR_W  = $clog2(WR_PULSE + 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BUS_WIDTH - 1);
   localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(WR_PULSE - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_SEND,
      ST_WRITE,
      ST_DONE
   } state_t;

   state_t                r_state;
   logic [BIT_W-1:0]      r_bit_cnt;
   logic [WR_W-1:0]       r_wr_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_s2p_en;
   logic                  r_s2p_send;
   logic                  r_mram_we;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;

   assign s2p_din   = serial_in;
   assign s2p_en    = r_s2p_en;
   assign s2p_send  = r_s2p_send;
   assign mram_we   = r_mram_we;
   assign mram_addr = r_addr;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;

   // NOTE: every register here is state, so only non-blocking assignments are
   // used; the async clear drives all outputs low without waiting for clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= '0;
         r_wr_cnt   <= '0;
         r_addr     <= '0;
         r_s2p_en   <= 1'b0;
         r_s2p_send <= 1'b0;
         r_mram_we  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         // Setting wins over clearing when both happen in the same cycle.
         if (start && r_busy) begin
            r_err <= 1'b1;
         end else if (clr_err) begin
            r_err <= 1'b0;
         end

         unique case (r_state)
            ST_IDLE: begin
               if (load_addr) begin
                  r_addr <= base_addr;
               end
               if (start && !abort) begin
                  r_state   <= ST_SHIFT;
                  r_bit_cnt <= '0;
                  r_s2p_en  <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end

            ST_SHIFT: begin
               if (abort) begin
                  r_state  <= ST_IDLE;
                  r_s2p_en <= 1'b0;
                  r_busy   <= 1'b0;
               end else if (r_bit_cnt == BIT_LAST) begin
                  r_state    <= ST_SEND;
                  r_s2p_en   <= 1'b0;
                  r_s2p_send <= 1'b1;
               end else begin
                  r_bit_cnt <= r_bit_cnt + BIT_W'(1);
               end
            end

            ST_SEND: begin
               r_s2p_send <= 1'b0;
               if (abort) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state   <= ST_WRITE;
                  r_wr_cnt  <= '0;
                  r_mram_we <= 1'b1;
               end
            end

            ST_WRITE: begin
               if (abort) begin
                  r_state   <= ST_IDLE;
                  r_mram_we <= 1'b0;
                  r_busy    <= 1'b0;
               end else if (r_wr_cnt == WR_LAST) begin
                  r_state   <= ST_DONE;
                  r_mram_we <= 1'b0;
                  r_done    <= 1'b1;
               end else begin
                  r_wr_cnt <= r_wr_cnt + WR_W'(1);
               end
            end

            ST_DONE: begin
               r_state <= ST_IDLE;
               r_addr  <= r_addr + ADDR_WIDTH'(1);
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end

            default: begin
               r_state    <= ST_IDLE;
               r_s2p_en   <= 1'b0;
               r_s2p_send <= 1'b0;
               r_mram_we  <= 1'b0;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_s2p_write_ctrl.sv
// Directed bench for s2p_write_ctrl: runs words through the controller and
// compares pulse counts, timing, addresses and error flag with hand values.
module tb_s2p_write_ctrl;

   localparam int BW = 16;
   localparam int AW = 8;
   localparam int WP = 4;
   localparam int LAT = BW + WP + 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic          serial_in;
   logic          load_addr;
   logic [AW-1:0] base_addr;
   logic          clr_err;
   logic          s2p_en;
   logic          s2p_din;
   logic          s2p_send;
   logic          mram_we;
   logic [AW-1:0] mram_addr;
   logic          busy;
   logic          done;
   logic          err;

   int n_checks = 0;
   int n_pass   = 0;

   // Observations gathered by run_word.
   int          en_cnt;
   int          send_cnt;
   int          we_cnt;
   int          done_cyc;
   int          addr_bad;
   logic        busy_after_abort;
   logic [BW-1:0] shreg;

   always #5 clk = ~clk;

   s2p_write_ctrl #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .WR_PULSE(WP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .serial_in (serial_in),
      .load_addr (load_addr),
      .base_addr (base_addr),
      .clr_err   (clr_err),
      .s2p_en    (s2p_en),
      .s2p_din   (s2p_din),
      .s2p_send  (s2p_send),
      .mram_we   (mram_we),
      .mram_addr (mram_addr),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts one word from IDLE and returns at the sample point of the done
   // cycle, of stop_cyc, or after a bounded number of cycles. Cycle k is the
   // k-th cycle after the edge that samples start.
   task automatic run_word(input logic [BW-1:0] w, input logic [AW-1:0] exp_addr,
                           input int start_cyc, input int abort_cyc,
                           input int clr_cyc, input int load_cyc, input int stop_cyc);
      en_cnt = 0; send_cnt = 0; we_cnt = 0; done_cyc = 0; addr_bad = 0;
      busy_after_abort = 1'bx; shreg = '0;
      start = 1'b1;
      serial_in = 1'b0;
      tick();
      start     = 1'b0;
      load_addr = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         serial_in = (cyc <= BW) ? w[cyc-1] : 1'b0;
         start     = (cyc == start_cyc);
         abort     = (cyc == abort_cyc);
         clr_err   = (cyc == clr_cyc);
         load_addr = (cyc == load_cyc);
         #1;
         if (s2p_en) begin
            en_cnt++;
            shreg = {s2p_din, shreg[BW-1:1]};
         end
         if (s2p_send) send_cnt++;
         if (mram_we) begin
            we_cnt++;
            if (mram_addr !== exp_addr) addr_bad++;
         end
         if (abort_cyc != 0 && cyc == abort_cyc + 1) busy_after_abort = busy;
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (cyc == stop_cyc) break;
         tick();
      end
   endtask

   task automatic check_normal(input string tag, input logic [BW-1:0] w);
      check({tag, "_en_cnt"},   en_cnt,   BW);
      check({tag, "_send_cnt"}, send_cnt, 1);
      check({tag, "_we_cnt"},   we_cnt,   WP);
      check({tag, "_done_cyc"}, done_cyc, LAT);
      check({tag, "_we_addr"},  addr_bad, 0);
      check({tag, "_word"},     shreg,    w);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; serial_in = 1'b0;
      load_addr = 1'b0; base_addr = '0; clr_err = 1'b0;

      // Reset state while rst_n is held low
      #12;
      check("rst_busy", busy, 0);
      check("rst_addr", mram_addr, 0);
      check("rst_err", err, 0);
      check("rst_en", s2p_en, 0);
      check("rst_send", s2p_send, 0);
      check("rst_we", mram_we, 0);
      check("rst_done", done, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      // Word 0xA5C3 at 0x10; load_addr during SHIFT must be ignored
      load_addr = 1'b1; base_addr = 8'h10;
      tick();
      load_addr = 1'b0;
      check("load_addr", mram_addr, 8'h10);
      base_addr = 8'h77;
      run_word(16'hA5C3, 8'h10, 0, 0, 0, 10, 0);
      check_normal("w1", 16'hA5C3);
      check("w1_addr_in_done", mram_addr, 8'h10);
      tick();
      check("w1_addr_next", mram_addr, 8'h11);
      check("w1_done_width", done, 0);
      check("w1_busy_idle", busy, 0);
      check("w1_err", err, 0);

      // Wrap at 0xFF, load together with start; start in DONE sets err only
      load_addr = 1'b1; base_addr = 8'hFF;
      run_word(16'h1234, 8'hFF, LAT, 0, 0, 0, 0);
      check_normal("wrap", 16'h1234);
      tick();
      start = 1'b0;
      check("wrap_addr", mram_addr, 8'h00);
      check("done_start_err", err, 1);
      check("done_start_ignored", busy, 0);
      tick();
      check("done_start_still_idle", busy, 0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("clr_err_idle", err, 0);

      // start during SHIFT cycle 5 sets err, word still completes
      run_word(16'h0F0F, 8'h00, 5, 0, 0, 0, 0);
      check_normal("errw", 16'h0F0F);
      check("err_set", err, 1);
      tick();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("err_cleared", err, 0);
      check("errw_addr", mram_addr, 8'h01);

      // Set and clear in the same cycle leaves err set
      run_word(16'hFFFF, 8'h01, 5, 0, 5, 0, 0);
      check("err_set_and_clr", err, 1);
      check("setclr_done_cyc", done_cyc, LAT);
      tick();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("err_cleared2", err, 0);
      check("setclr_addr", mram_addr, 8'h02);

      // Abort at SHIFT cycle 8
      run_word(16'hBEEF, 8'h02, 0, 8, 0, 0, 12);
      abort = 1'b0;
      check("abort_en_cnt", en_cnt, 8);
      check("abort_busy_next", busy_after_abort, 0);
      check("abort_send", send_cnt, 0);
      check("abort_we", we_cnt, 0);
      check("abort_no_done", done_cyc, 0);
      check("abort_addr", mram_addr, 8'h02);
      run_word(16'h5A5A, 8'h02, 0, 0, 0, 0, 0);
      check_normal("post_abort", 16'h5A5A);
      tick();
      check("post_abort_addr", mram_addr, 8'h03);

      // Reset during WRITE cycle 2 (cycle BW+3 after start)
      load_addr = 1'b1; base_addr = 8'h40;
      tick();
      load_addr = 1'b0;
      run_word(16'hC0DE, 8'h40, 0, 0, 0, 0, BW + 3);
      check("pre_rst_we", mram_we, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_we", mram_we, 0);
      check("midrst_busy", busy, 0);
      check("midrst_addr", mram_addr, 8'h00);
      tick();
      tick();
      check("midrst_no_done", done, 0);
      rst_n = 1'b1;
      run_word(16'h8001, 8'h00, 0, 0, 0, 0, 0);
      check_normal("after_rst", 16'h8001);
      tick();
      check("after_rst_addr", mram_addr, 8'h01);

      // Back-to-back: abort in DONE ignored, next start in first IDLE cycle
      load_addr = 1'b1; base_addr = 8'h30;
      tick();
      load_addr = 1'b0;
      run_word(16'h1357, 8'h30, 0, LAT, 0, 0, 0);
      check_normal("b2b_a", 16'h1357);
      tick();
      abort = 1'b0;
      check("b2b_addr_mid", mram_addr, 8'h31);
      run_word(16'h2468, 8'h31, 0, 0, 0, 0, 0);
      check_normal("b2b_b", 16'h2468);
      tick();
      check("b2b_addr_end", mram_addr, 8'h32);
      check("b2b_err", err, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
